load_store_unit: RTL and testbench

- Sits between the core's memory stage and the 1024x32 word-addressed data RAM.
- Converts RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) into whole-word RAM accesses.
- Performs read-modify-write for sub-word stores, and sign/zero extension for sub-word loads.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_align.sv | 38 +++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// access sizes and the request-decoding helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } lsu_size_e;

    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = BYTE;
            F3_H, F3_HU: sz = HALF;
            default:     sz = WORD;
        endcase
        return sz;
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extracts and extends load data from a RAM word, and merges
// sub-word store data into a RAM word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'h0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'h0, half_sel};
            default: load_data_o = word_i;
        endcase

        // Untouched lanes pass through from the read word unchanged.
        store_word_o = word_i;
        case (f3_size(funct3_i))
            BYTE:    store_word_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            HALF:    store_word_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed RAM: one request at a time,
// read-modify-write for SB/SH, sign/zero extension for sub-word loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned SIZE_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] ram_addr,
    output logic        ram_wr_sig,
    output logic [31:0] ram_wr_data,
    input  logic [31:0] ram_rd_data,
    output lsu_state_e  state_o
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so inputs are ignored while a request is in flight.

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic [31:0] ram_addr_q;

    logic [32:0] diff;
    logic        in_range;
    logic        aligned;
    logic        req_ok;
    logic        accept;
    logic [31:0] align_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    always_comb begin
        // 33-bit subtraction so an address below BASE_ADDR shows up as a borrow.
        diff     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        in_range = !diff[32] && (diff[31:0] < SIZE_BYTES);
        case (f3_size(req_funct3))
            HALF:    aligned = !req_addr[0];
            WORD:    aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        req_ok = funct3_legal(req_we, req_funct3) && aligned && in_range;
        accept = req_valid && (state_q == IDLE);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_ok)
                        state_d = ERR;
                    else if (req_we && (f3_size(req_funct3) == WORD))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In RD the fresh RAM word feeds extraction; in WR the captured word feeds the merge.
    assign align_word = (state_q == RD) ? ram_rd_data : word_q;

    lsu_align u_align (
        .word_i       (align_word),
        .wdata_i      (wdata_q),
        .offset_i     (offset_q),
        .funct3_i     (funct3_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            rdata_q    <= 32'h0;
            ram_addr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                offset_q <= req_addr[1:0];
                wdata_q  <= req_wdata;
                if (req_ok)
                    ram_addr_q <= diff[31:0];
            end
            if (state_q == RD) begin
                word_q <= ram_rd_data;
                if (!we_q)
                    rdata_q <= load_data;
            end
            if (state_q == ERR)
                rdata_q <= 32'h0;
        end
    end

    // Write enable is masked by reset so an abandoned request never reaches the RAM.
    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP) || (state_q == ERR);
    assign resp_err    = (state_q == ERR);
    assign resp_rdata  = (state_q == ERR) ? 32'h0 : rdata_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_sig  = (state_q == WR) && !reset;
    assign ram_wr_data = (state_q == WR) ? store_word : 32'h0;
    assign state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written reset and
// back-to-back sequences, and randomized requests against a reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          SIZE = 4096;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr_sig;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;
    lsu_state_e  state_o;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .ram_addr    (ram_addr),
        .ram_wr_sig  (ram_wr_sig),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .state_o     (state_o)
    );

    assign ram_rd_data = mem[ram_addr[11:2]];
    always @(posedge clk) begin
        if (ram_wr_sig)
            mem[ram_addr[11:2]] <= ram_wr_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},   32'(req_ready),   32'd1);
        chk({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        chk({tag, "_resp_err"},    32'(resp_err),    32'd0);
        chk({tag, "_resp_rdata"},  resp_rdata,       32'd0);
        chk({tag, "_ram_wr_sig"},  32'(ram_wr_sig),  32'd0);
        chk({tag, "_ram_addr"},    ram_addr,         32'd0);
        chk({tag, "_ram_wr_data"}, ram_wr_data,      32'd0);
        chk({tag, "_state"},       32'(state_o),     32'(IDLE));
    endtask

    // Reference model: computes the outcome from the ISA rules with plain arithmetic
    // and updates ref_mem for successful stores.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic e_err,
                         output logic [31:0] e_rdata, output int e_lat, output int e_wcyc);
        int          nb;
        bit          sgn;
        longint      a;
        int          idx;
        int          sh;
        logic [31:0] mask;
        logic [31:0] v;
        nb  = 0;
        sgn = 1'b0;
        case (f3)
            3'd0:    begin nb = 1; sgn = 1'b1; end
            3'd1:    begin nb = 2; sgn = 1'b1; end
            3'd2:    nb = 4;
            3'd4:    nb = we ? 0 : 1;
            3'd5:    nb = we ? 0 : 2;
            default: nb = 0;
        endcase
        a = longint'(addr) - longint'(BASE);
        e_err = (nb == 0);
        if (!e_err)
            e_err = (a < 0) || (a >= SIZE) || ((addr % 32'(nb)) != 32'd0);
        e_rdata = 32'h0;
        e_lat   = 1;
        e_wcyc  = 0;
        if (!e_err) begin
            idx  = int'(a) / 4;
            sh   = int'(addr % 32'd4) * 8;
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            if (!we) begin
                v = (ref_mem[idx] >> sh) & mask;
                if (sgn && nb < 4 && v > (mask >> 1))
                    v = v | ~mask;
                e_rdata = v;
                e_lat   = 2;
            end else begin
                ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
                e_lat  = (nb == 4) ? 2 : 3;
                e_wcyc = e_lat - 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge where resp_valid was seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic a_err,
                          output logic [31:0] a_rdata, output int a_lat, output int a_wcnt,
                          output int a_wcyc, output logic [31:0] a_waddr);
        int g;
        a_err = 1'b0; a_rdata = 32'h0; a_lat = 0; a_wcnt = 0; a_wcyc = 0; a_waddr = 32'h0;
        g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1)
                req_valid = 1'b0;
            if (ram_wr_sig) begin
                a_wcnt++;
                a_wcyc  = k;
                a_waddr = ram_addr;
            end
            if (resp_valid) begin
                a_lat   = k;
                a_err   = resp_err;
                a_rdata = resp_rdata;
                break;
            end
        end
    endtask

    task automatic run_check(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic a_err,
                             output logic [31:0] a_rdata);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] a_waddr;
        int          e_lat, e_wcyc, a_lat, a_wcnt, a_wcyc;
        logic [31:0] widx;
        model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_wcyc);
        do_req(we, f3, addr, wdata, a_err, a_rdata, a_lat, a_wcnt, a_wcyc, a_waddr);
        chk($sformatf("err@%h", addr),         32'(a_err),  32'(e_err));
        chk($sformatf("latency@%h", addr),     32'(a_lat),  32'(e_lat));
        chk($sformatf("write_count@%h", addr), 32'(a_wcnt), (e_wcyc != 0) ? 32'd1 : 32'd0);
        chk($sformatf("write_cycle@%h", addr), 32'(a_wcyc), 32'(e_wcyc));
        if (e_wcyc != 0)
            chk($sformatf("write_addr@%h", addr), a_waddr, addr - BASE);
        if (!we || e_err)
            chk($sformatf("rdata@%h", addr), a_rdata, e_rdata);
        widx = ((addr - BASE) >> 2) & 32'd1023;
        chk($sformatf("mem_word@%h", addr), mem[widx], ref_mem[widx]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic e_err,
                                input logic [31:0] e_rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.e_err = e_err; v.e_rdata = e_rdata;
        return v;
    endfunction

    initial begin
        logic        a_err;
        logic [31:0] a_rdata;
        logic [31:0] exp_q[$];
        logic [31:0] b2b_addr[3];
        int          n_sent, n_resp, overlap, wr_seen;
        bit          acc;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          sel;

        // reset block
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        vecs.push_back(mk(1, F3_W,   32'h10,  32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(0, F3_W,   32'h10,  32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, F3_W,   32'h10,  32'h11223344, 0, 32'h0));
        vecs.push_back(mk(1, F3_B,   32'h12,  32'h000000AA, 0, 32'h0));
        vecs.push_back(mk(0, F3_W,   32'h10,  32'h0,        0, 32'h11AA3344));
        vecs.push_back(mk(0, F3_B,   32'h12,  32'h0,        0, 32'hFFFFFFAA));
        vecs.push_back(mk(0, F3_BU,  32'h12,  32'h0,        0, 32'h000000AA));
        vecs.push_back(mk(0, F3_B,   32'h11,  32'h0,        0, 32'h00000033));
        vecs.push_back(mk(0, F3_B,   32'h13,  32'h0,        0, 32'h00000011));
        vecs.push_back(mk(1, F3_W,   32'h20,  32'h80017FFF, 0, 32'h0));
        vecs.push_back(mk(0, F3_H,   32'h22,  32'h0,        0, 32'hFFFF8001));
        vecs.push_back(mk(0, F3_HU,  32'h22,  32'h0,        0, 32'h00008001));
        vecs.push_back(mk(0, F3_H,   32'h20,  32'h0,        0, 32'h00007FFF));
        vecs.push_back(mk(1, F3_H,   32'h22,  32'hFFFF1234, 0, 32'h0));
        vecs.push_back(mk(0, F3_W,   32'h20,  32'h0,        0, 32'h12347FFF));
        vecs.push_back(mk(0, F3_W,   32'h13,  32'h0,        1, 32'h0));
        vecs.push_back(mk(1, F3_H,   32'h21,  32'h5555,     1, 32'h0));
        vecs.push_back(mk(0, F3_W,   32'h1000, 32'h0,       1, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h10,  32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h10,  32'h77,       1, 32'h0));
        vecs.push_back(mk(1, 3'b011, 32'h20,  32'h77,       1, 32'h0));
        vecs.push_back(mk(0, F3_W,   32'h10,  32'h0,        0, 32'h11AA3344));
        vecs.push_back(mk(1, F3_W,   32'hFFC, 32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mk(0, F3_HU,  32'hFFE, 32'h0,        0, 32'h0000CAFE));
        vecs.push_back(mk(0, F3_B,   32'hFFF, 32'h0,        0, 32'hFFFFFFCA));
        vecs.push_back(mk(0, F3_H,   32'hFFD, 32'h0,        1, 32'h0));

        foreach (vecs[i]) begin
            run_check(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, a_err, a_rdata);
            chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].e_err));
            if (!vecs[i].we)
                chk($sformatf("vec%0d_rdata", i), a_rdata, vecs[i].e_rdata);
        end

        // back-to-back: req_valid stays high across three loads
        b2b_addr = '{32'h10, 32'h20, 32'hFFC};
        n_sent = 0; n_resp = 0; overlap = 0;
        req_we = 1'b0; req_funct3 = F3_W; req_wdata = 32'h0;
        req_addr = b2b_addr[0];
        req_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            acc = req_valid && req_ready;
            if (acc)
                exp_q.push_back(ref_mem[(req_addr - BASE) >> 2]);
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                n_sent++;
                if (n_sent < 3) req_addr = b2b_addr[n_sent];
                else            req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (req_ready) overlap++;
                if (exp_q.size() != 0)
                    chk($sformatf("b2b_rdata%0d", n_resp), resp_rdata, exp_q.pop_front());
                n_resp++;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts",   32'(n_sent),  32'd3);
        chk("b2b_responses", 32'(n_resp),  32'd3);
        chk("b2b_overlap",   32'(overlap), 32'd0);

        // randomized phase: seed a small window, then mix loads/stores/errors
        for (int w = 0; w < 16; w++)
            run_check(1'b1, F3_W, BASE + 32'(w * 4), $urandom, a_err, a_rdata);
        for (int n = 0; n < 200; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 9);
            if (sel == 0)      r_addr = 32'h1000 + 32'($urandom_range(0, 7));
            else if (sel == 1) r_addr = $urandom;
            else               r_addr = BASE + 32'($urandom_range(0, 63));
            run_check(r_we, r_f3, r_addr, $urandom, a_err, a_rdata);
        end

        // reset held two cycles while an SB sits in RD
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = BASE + 32'h31; req_wdata = 32'h0000005A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_state_rd", 32'(state_o), 32'(RD));
        reset = 1'b1;
        wr_seen = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ram_wr_sig) wr_seen++;
            chk_reset_vals($sformatf("mid_reset%0d", k));
        end
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (ram_wr_sig) wr_seen++;
            @(negedge clk);
        end
        chk("mid_no_write", 32'(wr_seen), 32'd0);
        chk("mid_mem_word", mem[12], ref_mem[12]);
        run_check(1'b0, F3_W, BASE + 32'h30, 32'h0, a_err, a_rdata);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
